// File: rtl/move_pulser_if.sv
// rtl/move_pulser_if.sv - player button inputs and move pulse outputs of move_pulser
interface move_pulser_if #(
  parameter int CNT_W = 8
);
  logic             btn_n;
  logic             btn_s;
  logic             btn_e;
  logic             btn_w;
  logic             sw_v;
  logic             n;
  logic             s;
  logic             e;
  logic             w;
  logic             v;
  logic             busy;
  logic [CNT_W-1:0] move_count;

  // Player / stimulus side: drives raw buttons, observes moves.
  modport master (
    output btn_n, btn_s, btn_e, btn_w, sw_v,
    input  n, s, e, w, v, busy, move_count
  );

  // Pulser side: consumes raw buttons, produces moves.
  modport slave (
    input  btn_n, btn_s, btn_e, btn_w, sw_v,
    output n, s, e, w, v, busy, move_count
  );
endinterface

// File: rtl/move_pulser.sv
// rtl/move_pulser.sv - debounced one-shot move pulser for the labyrinth room FSM
module move_pulser #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input logic          clk,
  input logic          reset,
  move_pulser_if.slave bus
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, HOLD} state_t;

  // Bit order {n, s, e, w, v}; dir bits are [4:1].
  logic [4:0]    raw;
  logic [4:0]    sync1;
  logic [4:0]    sync2;
  logic [4:0]    stable;
  logic [DW-1:0] dcnt [5];

  state_t           state_q, state_d;
  logic [3:0]       dir_q, dir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             v_q;

  assign raw = {bus.btn_n, bus.btn_s, bus.btn_e, bus.btn_w, bus.sw_v};

  // Two-flop synchronizer for every raw input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: accept a change only after it persists DEBOUNCE_CYCLES edges.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stable <= '0;
      for (int i = 0; i < 5; i++) dcnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DLAST) begin
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  // FSM state, registered pulses, move counter and debounced v level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= '0;
      cnt_q   <= '0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      v_q     <= stable[0];
    end
  end

  // Next state: pick one winner in IDLE, pulse for one cycle, then wait for full release.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (|stable[4:1]) begin
          state_d = FIRE;
          if (stable[4])      dir_d = 4'b1000;
          else if (stable[3]) dir_d = 4'b0100;
          else if (stable[2]) dir_d = 4'b0010;
          else                dir_d = 4'b0001;
        end
      end
      FIRE: begin
        state_d = HOLD;
        dir_d   = '0;
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end
      HOLD: begin
        if (stable[4:1] == 4'b0000) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        dir_d   = '0;
      end
    endcase
  end

  assign bus.n          = dir_q[3];
  assign bus.s          = dir_q[2];
  assign bus.e          = dir_q[1];
  assign bus.w          = dir_q[0];
  assign bus.v          = v_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.move_count = cnt_q;

endmodule

// File: tb/tb_move_pulser.sv
// tb/tb_move_pulser.sv - scoreboard bench for move_pulser
module tb_move_pulser;
  localparam int D = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0, sw_v = 1'b0;

  always #5 clk = ~clk;

  move_pulser_if #(.CNT_W(8)) bus ();
  move_pulser_if #(.CNT_W(2)) bus2 ();

  assign bus.btn_n  = btn_n;
  assign bus.btn_s  = btn_s;
  assign bus.btn_e  = btn_e;
  assign bus.btn_w  = btn_w;
  assign bus.sw_v   = sw_v;
  assign bus2.btn_n = btn_n;
  assign bus2.btn_s = btn_s;
  assign bus2.btn_e = btn_e;
  assign bus2.btn_w = btn_w;
  assign bus2.sw_v  = sw_v;

  move_pulser #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut  (.clk(clk), .reset(reset), .bus(bus));
  move_pulser #(.DEBOUNCE_CYCLES(D), .CNT_W(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] dir;
    int         at;
    int         cnt;
  } exp_t;

  exp_t q[$];
  exp_t mx;
  int   pass_cnt = 0;
  int   total    = 0;
  int   exp_cnt  = 0;
  logic [3:0] p;

  assign p = {bus.n, bus.s, bus.e, bus.w};

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (p != 4'b0000) begin
        check("pulse_onehot", $countones(p), 1);
        if (q.size() == 0) begin
          check("unexpected_pulse", int'(p), 0);
        end else begin
          mx = q.pop_front();
          check("pulse_dir", int'(p), int'(mx.dir));
          check("pulse_cycle", cyc, mx.at);
          check("count_at_pulse", int'(bus.move_count), mx.cnt);
        end
      end else if (q.size() > 0 && cyc > q[0].at) begin
        check("missed_pulse", 0, int'(q[0].dir));
        void'(q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called right after a button is driven at a negedge.
  task automatic expect_pulse(input logic [3:0] d);
    exp_t x;
    x.dir = d;
    x.at  = cyc + 3 + D;
    x.cnt = exp_cnt;
    q.push_back(x);
    exp_cnt++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (q.size() > 0 && n < budget) begin
      tick(1);
      n++;
    end
    tick(1);
    if (q.size() > 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  int busy_seen;
  int c0;

  initial begin
    tick(3);
    check("rst_n", int'(bus.n), 0);
    check("rst_s", int'(bus.s), 0);
    check("rst_e", int'(bus.e), 0);
    check("rst_w", int'(bus.w), 0);
    check("rst_v", int'(bus.v), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_count", int'(bus.move_count), 0);
    reset   = 1'b0;
    exp_cnt = 0;
    tick(2);

    // Saturating count on the 2-bit instance: 1,2,3,3,3.
    for (int i = 1; i <= 5; i++) begin
      btn_n = 1'b1;
      expect_pulse(4'b1000);
      tick(5 + D);
      check("cnt2_sat", int'(bus2.move_count), (i < 3) ? i : 3);
      btn_n = 1'b0;
      tick(D + 6);
    end
    drain(50);

    // Single long press gives a single pulse at the exact latency.
    btn_n = 1'b1;
    expect_pulse(4'b1000);
    tick(20);
    check("hold_count", int'(bus.move_count), exp_cnt);
    check("hold_busy", int'(bus.busy), 1);
    btn_n = 1'b0;
    tick(D + 6);
    check("release_busy", int'(bus.busy), 0);

    // Short glitches never reach the FSM.
    busy_seen = 0;
    for (int i = 0; i < 4; i++) begin
      btn_e = (i % 2 == 0);
      tick(1);
      if (bus.busy) busy_seen = 1;
    end
    btn_e = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      if (bus.busy) busy_seen = 1;
    end
    check("glitch_busy", busy_seen, 0);
    check("glitch_count", int'(bus.move_count), exp_cnt);

    // Simultaneous n+e: priority n, then a fresh e press.
    btn_n = 1'b1;
    btn_e = 1'b1;
    expect_pulse(4'b1000);
    tick(6 + D);
    btn_n = 1'b0;
    btn_e = 1'b0;
    tick(D + 6);
    btn_e = 1'b1;
    expect_pulse(4'b0010);
    tick(D + 6);
    btn_e = 1'b0;
    tick(D + 6);
    drain(50);

    // Press during HOLD is ignored; busy until every dir is released.
    btn_w = 1'b1;
    expect_pulse(4'b0001);
    tick(5 + D);
    btn_s = 1'b1;
    tick(D + 6);
    btn_w = 1'b0;
    tick(D + 6);
    check("hold_s_busy", int'(bus.busy), 1);
    btn_s = 1'b0;
    tick(D + 6);
    check("all_released_busy", int'(bus.busy), 0);
    drain(50);
    check("after_hold_count", int'(bus.move_count), exp_cnt);

    // Debounced v level latency.
    sw_v = 1'b1;
    tick(2 + D);
    check("v_before", int'(bus.v), 0);
    tick(1);
    check("v_after", int'(bus.v), 1);
    sw_v = 1'b0;
    tick(D + 6);
    check("v_release", int'(bus.v), 0);

    // Reset one cycle after FIRE with s held, then re-detection.
    btn_s = 1'b1;
    expect_pulse(4'b0100);
    tick(3 + D);
    tick(1);
    reset = 1'b1;
    #1;
    check("midrst_pulses", int'(p), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_count", int'(bus.move_count), 0);
    if (q.size() > 0) begin
      check("midrst_pending", q.size(), 0);
      q.delete();
    end
    exp_cnt = 0;
    tick(2);
    reset = 1'b0;
    expect_pulse(4'b0100);
    tick(5 + D);
    check("postrst_count", int'(bus.move_count), 1);
    btn_s = 1'b0;
    tick(D + 6);
    drain(50);
    check("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
